// File: rtl/port_io_pkg.sv
// Shared encodings for the output-port UART transmitter: FSM states, frame width, idle line level.
// Parity helper is only referenced when PORT_UART_TX_PARITY_EN is defined.
package port_io_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic TX_IDLE_LEVEL  = 1'b1;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/port_fifo.sv
// Synchronous FIFO with show-ahead head (dout valid whenever level>0); one-cycle push-to-level latency.
// Push while full is ignored, pop while empty is ignored; simultaneous push/pop keeps level.
module port_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && (level_q != '0);

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + (PW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - (PW+1)'(1);
    end
  end

  // Pointers wrap modulo DEPTH by their natural width (DEPTH is a power of two).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (level_q == (PW+1)'(DEPTH));
  assign level = level_q;

endmodule

// File: rtl/port_uart_tx.sv
// Queues cpu out_p0 bytes and serialises them 8N1 (8E1 with PORT_UART_TX_PARITY_EN); start bit one cycle after a write to an idle FIFO.
// Never stalls the cpu: writes into a full FIFO are dropped and latch the sticky overflow flag.
module port_uart_tx
  import port_io_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   tx,
  output logic                   busy,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_e                 state_q, state_d;
  logic [BW-1:0]             baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      overflow_q, overflow_d;
  logic                      pop;
  logic                      baud_last;
  logic [7:0]                fifo_dout;
`ifdef PORT_UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  port_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .level (level)
  );

  assign baud_last  = (baud_q == BAUD_LAST);
  assign overflow_d = overflow_q | (wr_en & full);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
`ifdef PORT_UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
`ifdef PORT_UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef PORT_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (level != '0) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
`ifdef PORT_UART_TX_PARITY_EN
          par_d   = even_parity(fifo_dout);
`endif
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
`ifdef PORT_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef PORT_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave without an idle gap.
          if (level != '0) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
`ifdef PORT_UART_TX_PARITY_EN
            par_d   = even_parity(fifo_dout);
`endif
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
`ifdef PORT_UART_TX_PARITY_EN
      PARITY:  tx = par_q;
`endif
      default: tx = TX_IDLE_LEVEL;
    endcase
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Directed bench for port_uart_tx at CLKS_PER_BIT=4, DEPTH=4; outputs sampled 1 time unit after each rising edge.
module tb_port_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef PORT_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx, busy, full, overflow;
  logic [2:0] level;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  port_uart_tx #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .level    (level),
    .overflow (overflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Line bits in time order, bit 0 first: start, data LSB first, [parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef PORT_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, 1'b1, b, 1'b0};
`endif
  endfunction

  task automatic test_reset;
    reset = 1'b0; wr_en = 1'b1; wr_data = 8'h5A;
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx_t0: got %b want 1", tx); end
    for (int i = 0; i < 2; i++) begin
      tick;
      vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
    end
    reset = 1'b1; wr_en = 1'b0;
    tick;
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL reset_release_level: got %0d want 0", level); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_single;
    logic [10:0] f;
    f = 11'b11_00001000_0;
    wr_en = 1'b1; wr_data = 8'h08;
    tick;
    wr_en = 1'b0; wr_data = 8'hFF;
    vectors++; if (level !== 3'd1) begin miscompares++; $display("FAIL single_level_queued: got %0d want 1", level); end
    vectors++; if (tx !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL single_pre_start: tx=%b busy=%b want tx=1 busy=0", tx, busy); end
    for (int c = 0; c < FL; c++) begin
      tick;
      vectors++; if (tx !== f[c / CPB]) begin miscompares++; $display("FAIL single_tx c=%0d: got %b want %b", c, tx, f[c / CPB]); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy c=%0d: got %b want 1", c, busy); end
      if (c == 0) begin
        vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL single_level_popped: got %0d want 0", level); end
      end
    end
    tick;
    vectors++; if (busy !== 1'b0 || tx !== 1'b1) begin miscompares++; $display("FAIL single_end: busy=%b tx=%b want busy=0 tx=1", busy, tx); end
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL single_end_level: got %0d want 0", level); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] f0, f1;
    logic        e;
    f0 = 11'b11_00001000_0;
    f1 = 11'b11_00000100_0;
    wr_en = 1'b1; wr_data = 8'h08;
    tick;
    wr_data = 8'h04;
    for (int c = 0; c < 2 * FL; c++) begin
      tick;
      wr_en = 1'b0;
      if (c == 0) begin
        vectors++; if (level !== 3'd1) begin miscompares++; $display("FAIL b2b_push_pop_level: got %0d want 1", level); end
      end
      e = (c < FL) ? f0[c / CPB] : f1[(c - FL) / CPB];
      vectors++; if (tx !== e) begin miscompares++; $display("FAIL b2b_tx c=%0d: got %b want %b", c, tx, e); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy c=%0d: got %b want 1", c, busy); end
    end
    tick;
    vectors++; if (busy !== 1'b0 || tx !== 1'b1) begin miscompares++; $display("FAIL b2b_end: busy=%b tx=%b want busy=0 tx=1", busy, tx); end
  endtask

  task automatic test_overflow;
    logic [7:0]  d [6];
    int          exp_lvl [6];
    logic        exp_full [6];
    logic        exp_ovf [6];
    logic [10:0] f [5];
    logic        e;
    d        = '{8'hA1, 8'h3C, 8'h5E, 8'h81, 8'hF0, 8'h66};
    exp_lvl  = '{1, 1, 2, 3, 4, 4};
    exp_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_ovf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) f[i] = frame_of(d[i]);
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = d[i];
      tick;
      vectors++; if (level !== 3'(exp_lvl[i])) begin miscompares++; $display("FAIL ovf_level w=%0d: got %0d want %0d", i, level, exp_lvl[i]); end
      vectors++; if (full !== exp_full[i]) begin miscompares++; $display("FAIL ovf_full w=%0d: got %b want %b", i, full, exp_full[i]); end
      vectors++; if (overflow !== exp_ovf[i]) begin miscompares++; $display("FAIL ovf_flag w=%0d: got %b want %b", i, overflow, exp_ovf[i]); end
      if (i > 0) begin
        vectors++; if (tx !== f[0][(i - 1) / CPB]) begin miscompares++; $display("FAIL ovf_tx c=%0d: got %b want %b", i - 1, tx, f[0][(i - 1) / CPB]); end
      end
    end
    wr_en = 1'b0; wr_data = 8'h00;
    for (int c = 5; c < 5 * FL; c++) begin
      tick;
      e = f[c / FL][(c % FL) / CPB];
      vectors++; if (tx !== e) begin miscompares++; $display("FAIL ovf_drain_tx c=%0d: got %b want %b", c, tx, e); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ovf_drain_busy c=%0d: got %b want 1", c, busy); end
    end
    tick;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovf_end_busy: got %b want 0", busy); end
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL ovf_end_level: got %0d want 0", level); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_mid_reset;
    wr_en = 1'b1; wr_data = 8'h37;
    tick;
    wr_data = 8'h55;
    tick;
    wr_en = 1'b0;
    for (int c = 1; c < 18; c++) tick;
    // Now inside DATA bit 3 of 0x37, which is a 0 on the line.
    vectors++; if (tx !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL midrst_pre: tx=%b busy=%b want tx=0 busy=1", tx, busy); end
    vectors++; if (level !== 3'd1) begin miscompares++; $display("FAIL midrst_pre_level: got %0d want 1", level); end
    reset = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL midrst_tx_async: got %b want 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy_async: got %b want 0", busy); end
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL midrst_level_async: got %0d want 0", level); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    tick;
    reset = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick;
      vectors++; if (tx !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_quiet c=%0d: tx=%b busy=%b want tx=1 busy=0", c, tx, busy); end
    end
    vectors++; if (level !== 3'd0) begin miscompares++; $display("FAIL midrst_end_level: got %0d want 0", level); end
  endtask

`ifdef PORT_UART_TX_PARITY_EN
  task automatic test_parity;
    logic [10:0] f;
    f = 11'b1_1_00000111_0;
    wr_en = 1'b1; wr_data = 8'h07;
    tick;
    wr_en = 1'b0;
    for (int c = 0; c < 44; c++) begin
      tick;
      vectors++; if (tx !== f[c / CPB]) begin miscompares++; $display("FAIL parity_tx c=%0d: got %b want %b", c, tx, f[c / CPB]); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL parity_busy c=%0d: got %b want 1", c, busy); end
    end
    tick;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL parity_len: busy=%b want 0 after 44 cycles", busy); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_mid_reset;
`ifdef PORT_UART_TX_PARITY_EN
    test_parity;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
- Output-port serial transmitter placed directly downstream of the cpu's out_p0 port.
- Each cpu write strobe pushes the current out_p0 byte into a small FIFO.
- An FSM drains the FIFO onto a single 8N1 UART line.
- Lets test programs emit byte streams observable on one wire without stalling the cpu.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  one-cycle write strobe from the cpu output-port decode.
- wr_data  input  8  byte to send; connected to cpu out_p0.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line (state != IDLE).
- full  output  1  FIFO holds DEPTH entries.
- level  output  $clog2(DEPTH)+1  number of FIFO entries currently held.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (reset=0, asynchronous): tx=1, busy=0, full=0, level=0, overflow=0, FIFO emptied, FSM=IDLE, bit and baud counters=0. Reset asserted mid-frame aborts the frame immediately; tx returns high in the same instant.
- Write handling:
  - A write is accepted when wr_en=1 and full=0, using the registered full value.
  - A write with full=1 is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Write and pop in the same cycle (non-full): level unchanged.
- FSM states: IDLE, START, DATA, STOP; all outputs registered.
  - IDLE: if level>0 at edge e, pop head into shift reg, go to START, tx=0 from edge e. A byte written at edge k therefore appears as tx=0 from edge k+1 (one-cycle latency from an idle FIFO).
  - START: holds tx=0 for CLKS_PER_BIT cycles, then goes to DATA with tx=shift[0].
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. Shift right after each bit. bit_cnt runs 0..7; after bit 7, go to STOP, tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - level>0: pop and go directly to START (no idle gap).
    - otherwise: go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads at each bit boundary, and is cleared on entry to START.
- FIFO: read and write pointers wrap modulo DEPTH. full = (level==DEPTH). level never exceeds DEPTH and never underflows, because the FSM pops only when level>0.
- wr_data is sampled only on accepted writes; later changes do not affect a queued byte.

Optional Feature:
- Macro: PORT_UART_TX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP.
  - Transmits the even-parity bit (XOR of the 8 data bits), held for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT cycles.
- Undefined: 8N1 framing only; no PARITY state or logic is synthesized.

Decomposition:
- Shared package port_io_pkg holds:
  - FSM state encoding constants: IDLE=0, START=1, DATA=2, STOP=3, PARITY=4.
  - UART_DATA_BITS=8.
  - TX_IDLE_LEVEL=1.
- One natural sub-module: port_fifo, a synchronous FIFO parameterized by DEPTH and WIDTH.
  - Ports: clk, reset, push, pop, din, dout, full, level.
  - Asynchronous active-low reset.
- port_uart_tx instantiates port_fifo and contains the FSM plus the baud and bit counters.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and DEPTH=4.
1. Reset: hold reset=0 for 2 cycles with wr_en=1 -> tx=1, busy=0, level=0, overflow=0 throughout.
2. Single byte: write 8'h08 at edge k -> tx=0 on edges k+1..k+4, then bits 0,0,0,1,0,0,0,0 at 4 cycles each, then stop=1 for 4 cycles; busy falls after 40 cycles; level returns to 0.
3. Back-to-back: write 8'h08 then 8'h04 on consecutive cycles -> second start bit begins the cycle after the first stop bit ends (no idle gap); total 80 cycles busy.
4. Overflow: while a frame is active, write 5 bytes on consecutive cycles. Expected on the first write: the FSM pops it immediately, so the remaining 4 writes fill the FIFO. Extend the burst to 6 writes -> the sixth is dropped, overflow=1 stays set, full=1 while level=4.
5. Mid-frame reset: pulse reset=0 for 1 cycle during DATA bit 3 -> tx=1 immediately, FIFO empty, no further frame emitted.
6. Parity (macro defined): write 8'h07 -> parity bit=1 after bit 7; frame length 44 cycles.
